// File: rtl/spi_rx_deserializer_if.sv
// Port bundle for spi_rx_deserializer: SPI lines in, valid/ready word port out.
// Carries frame_err only when SPI_RX_FRAME_CHECK_EN is defined.
interface spi_rx_deserializer_if #(
  parameter int WORD_W = 16
);
  logic              spi_sclk;
  logic              spi_cs_l;
  logic              spi_data;
  logic              rx_ready;
  logic              ovr_clr;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_overrun;
  logic [4:0]        bit_count;
`ifdef SPI_RX_FRAME_CHECK_EN
  logic              frame_err;
`endif

  modport slave (
    input  spi_sclk, spi_cs_l, spi_data, rx_ready, ovr_clr,
    output rx_data, rx_valid, rx_overrun, bit_count
`ifdef SPI_RX_FRAME_CHECK_EN
    , output frame_err
`endif
  );

  modport master (
    output spi_sclk, spi_cs_l, spi_data, rx_ready, ovr_clr,
    input  rx_data, rx_valid, rx_overrun, bit_count
`ifdef SPI_RX_FRAME_CHECK_EN
    , input frame_err
`endif
  );
endinterface

// File: rtl/spi_rx_deserializer.sv
// Oversampling SPI mode-0 receiver: rebuilds MSB-first WORD_W-bit frames onto a valid/ready port.
// Optional SPI_RX_FRAME_CHECK_EN adds a frame_err pulse for short frames and extra sclk edges.
module spi_rx_deserializer #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  spi_rx_deserializer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [4:0] LAST_BIT = 5'(WORD_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, data_sr;
  logic                   sclk_prev;
  logic                   sclk_sync, cs_sync, data_sync, rise;

  state_t                 state_q, state_d;
  logic [WORD_W-1:0]      shift_reg;
  logic [4:0]             bit_count;
  logic                   shift_en, cnt_clr, word_done_d, word_done_q;

  assign sclk_sync = sclk_sr[SYNC_STAGES-1];
  assign cs_sync   = cs_sr[SYNC_STAGES-1];
  assign data_sync = data_sr[SYNC_STAGES-1];
  assign rise      = sclk_sync & ~sclk_prev;

  // Idle-line reset values (sclk low, cs_l high) keep a reset release from looking like a frame start.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr   <= '0;
      cs_sr     <= '1;
      data_sr   <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], bus.spi_cs_l};
      data_sr   <= {data_sr[SYNC_STAGES-2:0], bus.spi_data};
      sclk_prev <= sclk_sync;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_en    = 1'b0;
    cnt_clr     = 1'b0;
    word_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_sync) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_sync) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (rise) begin
          shift_en = 1'b1;
          if (bit_count == LAST_BIT) begin
            state_d     = HOLD;
            word_done_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cs_sync) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_reg   <= '0;
      bit_count   <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_done_q <= word_done_d;
      if (shift_en) shift_reg <= {shift_reg[WORD_W-2:0], data_sync};
      if (cnt_clr)       bit_count <= '0;
      else if (shift_en) bit_count <= bit_count + 5'd1;
    end
  end

  // A completed word loads only if the output slot is empty or being drained this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.rx_overrun <= 1'b0;
    end else begin
      if (word_done_q && (!bus.rx_valid || bus.rx_ready)) begin
        bus.rx_data  <= shift_reg;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end

      if (word_done_q && bus.rx_valid && !bus.rx_ready) bus.rx_overrun <= 1'b1;
      else if (bus.ovr_clr)                             bus.rx_overrun <= 1'b0;
    end
  end

  assign bus.bit_count = bit_count;

`ifdef SPI_RX_FRAME_CHECK_EN
  logic frame_err_d, frame_err_q;

  assign frame_err_d = ((state_q == SHIFT) && cs_sync && (bit_count != 5'd0)) ||
                       ((state_q == HOLD) && !cs_sync && rise);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_err_q <= 1'b0;
    else       frame_err_q <= frame_err_d;
  end

  assign bus.frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Directed bench for spi_rx_deserializer: frame-level model compared every settled cycle,
// plus literal expectations for latency, overrun, short/long frames and reset.
module tb_spi_rx_deserializer;
  localparam int WORD_W = 16;
  localparam int HALF   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_rx_deserializer_if #(.WORD_W(WORD_W)) bus ();

  spi_rx_deserializer #(.WORD_W(WORD_W), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] m_data  = '0;
  bit                m_valid = 1'b0;
  bit                m_ovr   = 1'b0;
  int                m_count = 0;
  bit                settled = 1'b0;

  int valid_cycles = 0;
  always @(posedge clk) if (bus.rx_valid) valid_cycles++;

`ifdef SPI_RX_FRAME_CHECK_EN
  int ferr_cnt = 0;
  always @(posedge clk) if (bus.frame_err) ferr_cnt++;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model and DUT compared on every falling edge while no transfer is in flight.
  always @(negedge clk) begin
    if (settled) begin
      check("cmp_rx_valid",   32'(bus.rx_valid),   32'(m_valid));
      check("cmp_rx_data",    32'(bus.rx_data),    32'(m_data));
      check("cmp_rx_overrun", 32'(bus.rx_overrun), 32'(m_ovr));
      check("cmp_bit_count",  32'(bus.bit_count),  32'(m_count));
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_word(input logic [WORD_W-1:0] w);
    if (!m_valid || bus.rx_ready) begin
      m_data  = w;
      m_valid = !bus.rx_ready;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.spi_sclk = 1'b0;
    bus.spi_data = b;
    wait_neg(HALF);
    bus.spi_sclk = 1'b1;
    wait_neg(HALF);
  endtask

  task automatic end_frame();
    settled      = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_l = 1'b1;
    wait_neg(2 * HALF);
    m_count = 0;
    settled = 1'b1;
    wait_neg(2);
  endtask

  // Sends n bits of 'bits' MSB first; the first WORD_W bits form the word.
  task automatic spi_frame(input logic [31:0] bits, input int n, input bit close);
    settled      = 1'b0;
    bus.spi_cs_l = 1'b0;
    wait_neg(HALF);
    for (int i = n - 1; i >= 0; i--) drive_bit(bits[i]);
    bus.spi_sclk = 1'b0;
    wait_neg(2);
    if (n >= WORD_W) model_word(bits[n-1 -: WORD_W]);
    m_count = (n >= WORD_W) ? WORD_W : n;
    settled = 1'b1;
    wait_neg(4);
    if (close) end_frame();
  endtask

  task automatic consume();
    settled      = 1'b0;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("consume_valid_drop", 32'(bus.rx_valid), 32'd0);
    @(negedge clk);
    bus.rx_ready = 1'b0;
    m_valid      = 1'b0;
    settled      = 1'b1;
    wait_neg(2);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WORD_W-1:0] w6;
    int                vc;

    bus.spi_sclk = 1'b0;
    bus.spi_cs_l = 1'b1;
    bus.spi_data = 1'b0;
    bus.rx_ready = 1'b1;
    bus.ovr_clr  = 1'b0;
    #1;
    check("reset_rx_data",    32'(bus.rx_data),    32'd0);
    check("reset_rx_valid",   32'(bus.rx_valid),   32'd0);
    check("reset_rx_overrun", 32'(bus.rx_overrun), 32'd0);
    check("reset_bit_count",  32'(bus.bit_count),  32'd0);
    wait_neg(3);
    reset   = 1'b0;
    settled = 1'b1;
    wait_neg(2);

    // 1: single word, ready held high
    vc = valid_cycles;
    spi_frame(32'h0001, 16, 1'b1);
    check("t1_rx_data",      32'(bus.rx_data),   32'h0001);
    check("t1_valid_pulses", valid_cycles - vc,  32'd1);
    check("t1_overrun",      32'(bus.rx_overrun), 32'd0);

    // 2: two words without ready -> overrun, then clear and drain
    bus.rx_ready = 1'b0;
    spi_frame(32'h0002, 16, 1'b1);
    spi_frame(32'h0003, 16, 1'b1);
    check("t2_rx_data_kept", 32'(bus.rx_data),    32'h0002);
    check("t2_overrun_set",  32'(bus.rx_overrun), 32'd1);
    settled     = 1'b0;
    bus.ovr_clr = 1'b1;
    wait_neg(1);
    bus.ovr_clr = 1'b0;
    m_ovr       = 1'b0;
    wait_neg(1);
    check("t2_overrun_clr", 32'(bus.rx_overrun), 32'd0);
    settled = 1'b1;
    consume();

    // 3: 7-bit short frame dropped, then full frame intact
    bus.rx_ready = 1'b1;
    vc = valid_cycles;
`ifdef SPI_RX_FRAME_CHECK_EN
    ferr_cnt = 0;
`endif
    spi_frame(32'h0006, 7, 1'b1);
    check("t3_no_valid", valid_cycles - vc,   32'd0);
    check("t3_count_0",  32'(bus.bit_count),  32'd0);
`ifdef SPI_RX_FRAME_CHECK_EN
    check("t3_frame_err_once", 32'(ferr_cnt), 32'd1);
`endif
    spi_frame(32'h0D73, 16, 1'b1);
    check("t3_rx_data", 32'(bus.rx_data), 32'h0D73);

    // 4: 18 rises in one frame -> first 16 bits kept, count saturates
`ifdef SPI_RX_FRAME_CHECK_EN
    ferr_cnt = 0;
`endif
    spi_frame({14'd0, 16'hABCD, 2'b10}, 18, 1'b0);
    check("t4_bit_count", 32'(bus.bit_count), 32'd16);
    check("t4_rx_data",   32'(bus.rx_data),   32'hABCD);
    end_frame();
`ifdef SPI_RX_FRAME_CHECK_EN
    check("t4_frame_err_extra", 32'(ferr_cnt), 32'd2);
`endif

    // 5: reset mid-frame, then a clean frame
    bus.rx_ready = 1'b0;
    spi_frame(32'h00A5, 8, 1'b0);
    settled = 1'b0;
    reset   = 1'b1;
    #1;
    check("t5_rx_data",   32'(bus.rx_data),    32'd0);
    check("t5_rx_valid",  32'(bus.rx_valid),   32'd0);
    check("t5_overrun",   32'(bus.rx_overrun), 32'd0);
    check("t5_bit_count", 32'(bus.bit_count),  32'd0);
    bus.spi_sclk = 1'b0;
    bus.spi_cs_l = 1'b1;
    wait_neg(3);
    reset   = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_count = 0;
    settled = 1'b1;
    wait_neg(2);
    bus.rx_ready = 1'b1;
    spi_frame(32'h1234, 16, 1'b1);
    check("t5_rx_data_after", 32'(bus.rx_data), 32'h1234);

    // 6: new word completes in the same cycle the pending one is accepted
    bus.rx_ready = 1'b0;
    spi_frame(32'h5A5A, 16, 1'b1);
    w6 = 16'hC3C3;
    settled      = 1'b0;
    bus.spi_cs_l = 1'b0;
    wait_neg(HALF);
    for (int i = WORD_W - 1; i >= 1; i--) drive_bit(w6[i]);
    bus.spi_sclk = 1'b0;
    bus.spi_data = w6[0];
    wait_neg(HALF);
    bus.spi_sclk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.rx_ready = 1'b1;
    check("t6_old_data",  32'(bus.rx_data),  32'h5A5A);
    check("t6_old_valid", 32'(bus.rx_valid), 32'd1);
    @(posedge clk);
    #1;
    check("t6_new_data",  32'(bus.rx_data),    32'hC3C3);
    check("t6_new_valid", 32'(bus.rx_valid),   32'd1);
    check("t6_overrun",   32'(bus.rx_overrun), 32'd0);
    @(negedge clk);
    bus.rx_ready = 1'b0;
    wait_neg(HALF - 1);
    bus.spi_sclk = 1'b0;
    wait_neg(2);
    m_data  = w6;
    m_valid = 1'b1;
    m_count = WORD_W;
    settled = 1'b1;
    wait_neg(2);
    end_frame();
    consume();

    settled = 1'b0;
    wait_neg(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
